// File: rtl/tail_sprite_reader.sv
// tail_sprite_reader: per-scanline sprite ROM row fetch, MSB-first pixel serialiser and animation frame counter
module tail_sprite_reader #(
  parameter int ANIM_DIV = 8,
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          frame_tick,
  input  logic          line_start,
  input  logic [YW-1:0] line_v,
  input  logic          pix_en,
  input  logic [XW-1:0] hpos,
  input  logic [XW-1:0] spr_x,
  input  logic [YW-1:0] spr_y,
  output logic [3:0]    rom_y,
  output logic [1:0]    rom_frame,
  input  logic [15:0]   rom_bits,
  output logic          pixel_on,
  output logic [1:0]    anim_frame
);
  localparam int DW = ANIM_DIV > 1 ? $clog2(ANIM_DIV) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, ARMED, SHIFT} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] anim_q, anim_d;
  logic [3:0] rom_y_q, rom_y_d;
  logic [15:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic pixel_on_q, pixel_on_d;
  logic [YW:0] dy;
  logic dy_ok;
  logic div_wrap;
  assign dy = {1'b0, line_v} - {1'b0, spr_y};
  assign dy_ok = dy[YW:4] == '0;
  assign div_wrap = div_q == DW'(ANIM_DIV - 1);
  // animation divider: step the ROM frame once every ANIM_DIV video frames
  always_comb begin
    div_d = div_q;
    anim_d = anim_q;
    if (frame_tick) begin
      div_d = div_wrap ? '0 : div_q + 1'b1;
      anim_d = div_wrap ? anim_q + 2'd1 : anim_q;
    end
  end
  // row fetch and serialiser: line_start (re)arms, enable low forces idle
  always_comb begin
    state_d = state_q;
    rom_y_d = rom_y_q;
    row_d = row_q;
    col_d = col_q;
    pixel_on_d = pix_en ? 1'b0 : pixel_on_q;
    if (!enable) begin
      state_d = IDLE;
      pixel_on_d = 1'b0;
    end else if (line_start) begin
      state_d = dy_ok ? FETCH : IDLE;
      rom_y_d = dy_ok ? dy[3:0] : rom_y_q;
    end else begin
      case (state_q)
        FETCH: begin
          row_d = rom_bits;
          state_d = ARMED;
        end
        ARMED: if (pix_en && hpos == spr_x) begin
          pixel_on_d = row_q[15];
          col_d = 4'd1;
          state_d = SHIFT;
        end
        SHIFT: if (pix_en) begin
          pixel_on_d = row_q[~col_q];
          col_d = col_q + 4'd1;
          state_d = col_q == 4'd15 ? IDLE : SHIFT;
        end
        default: ;
      endcase
    end
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q <= '0;
      anim_q <= 2'd0;
      rom_y_q <= 4'd0;
      row_q <= 16'd0;
      col_q <= 4'd0;
      pixel_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      anim_q <= anim_d;
      rom_y_q <= rom_y_d;
      row_q <= row_d;
      col_q <= col_d;
      pixel_on_q <= pixel_on_d;
    end
  end
  assign rom_y = rom_y_q;
  assign rom_frame = anim_q;
  assign anim_frame = anim_q;
  assign pixel_on = pixel_on_q;
endmodule
